mem_access: RTL



---
 rtl/mem_access.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: load/store decode, alignment check, req/ack data bus, read capture
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [7:0]  aluop,
    input  logic [31:0] m_vaddr,
    input  logic [31:0] opr2,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] m_rdata,
    output logic        stallreq,
    output logic        exc_adel,
    output logic        exc_ades
);
    localparam logic [7:0] OP_LB  = 8'h20, OP_LH  = 8'h21, OP_LWL = 8'h22, OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24, OP_LHU = 8'h25, OP_LWR = 8'h26;
    localparam logic [7:0] OP_SB  = 8'h28, OP_SH  = 8'h29, OP_SWL = 8'h2a, OP_SW  = 8'h2b;
    localparam logic [7:0] OP_SWR = 8'h2e;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;
    state_t state, state_nxt;

    logic        is_load, is_store, addr_err, go;
    logic [1:0]  a;
    logic [3:0]  c_be;
    logic [31:0] c_wdata;
    logic [31:0] l_addr, l_wdata;
    logic [3:0]  l_be;
    logic        l_wr;

    assign a = m_vaddr[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        addr_err = 1'b0;
        c_be     = 4'b1111;
        c_wdata  = opr2;
        case (aluop)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load  = 1'b1;
                addr_err = a[0];
            end
            OP_LW: begin
                is_load  = 1'b1;
                addr_err = |a;
            end
            OP_SB: begin
                is_store = 1'b1;
                c_be     = 4'b0001 << a;
                c_wdata  = {4{opr2[7:0]}};
            end
            OP_SH: begin
                is_store = 1'b1;
                addr_err = a[0];
                c_be     = a[1] ? 4'b1100 : 4'b0011;
                c_wdata  = {2{opr2[15:0]}};
            end
            OP_SW: begin
                is_store = 1'b1;
                addr_err = |a;
            end
            OP_SWL: begin
                is_store = 1'b1;
                case (a)
                    2'b00:   begin c_be = 4'b0001; c_wdata = {24'b0, opr2[31:24]}; end
                    2'b01:   begin c_be = 4'b0011; c_wdata = {16'b0, opr2[31:16]}; end
                    2'b10:   begin c_be = 4'b0111; c_wdata = {8'b0, opr2[31:8]};   end
                    default: begin c_be = 4'b1111; c_wdata = opr2;                 end
                endcase
            end
            OP_SWR: begin
                is_store = 1'b1;
                case (a)
                    2'b00:   begin c_be = 4'b1111; c_wdata = opr2;                 end
                    2'b01:   begin c_be = 4'b1110; c_wdata = {opr2[23:0], 8'b0};   end
                    2'b10:   begin c_be = 4'b1100; c_wdata = {opr2[15:0], 16'b0};  end
                    default: begin c_be = 4'b1000; c_wdata = {opr2[7:0], 24'b0};   end
                endcase
            end
            default: ;
        endcase
    end

    assign exc_adel = is_load  & addr_err & ~flush;
    assign exc_ades = is_store & addr_err & ~flush;
    assign go       = (is_load | is_store) & ~addr_err & ~flush;

    always_comb begin
        state_nxt = state;
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_be    = 4'b0;
        bus_addr  = 32'b0;
        bus_wdata = 32'b0;
        stallreq  = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    bus_req   = 1'b1;
                    bus_wr    = is_store;
                    bus_be    = c_be;
                    bus_addr  = {m_vaddr[31:2], 2'b00};
                    bus_wdata = c_wdata;
                    stallreq  = ~bus_ack;
                    if (bus_ack) state_nxt = stall ? HOLD : IDLE;
                    else         state_nxt = BUSY;
                end
            end
            BUSY, DRAIN: begin
                bus_req   = 1'b1;
                bus_wr    = l_wr;
                bus_be    = l_be;
                bus_addr  = l_addr;
                bus_wdata = l_wdata;
                // The ack cycle of a live transaction releases the pipeline so the same op is not reissued
                stallreq  = (state == DRAIN) | ~bus_ack;
                if (state == DRAIN) begin
                    if (bus_ack) state_nxt = IDLE;
                end else if (bus_ack) begin
                    state_nxt = (stall & ~flush) ? HOLD : IDLE;
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            HOLD: if (~stall | flush) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            l_addr  <= 32'b0;
            l_wdata <= 32'b0;
            l_be    <= 4'b0;
            l_wr    <= 1'b0;
            m_rdata <= 32'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && go) begin
                l_addr  <= {m_vaddr[31:2], 2'b00};
                l_wdata <= c_wdata;
                l_be    <= c_be;
                l_wr    <= is_store;
            end
            if (bus_ack && ((state == IDLE && go && is_load) || (state == BUSY && !l_wr)))
                m_rdata <= bus_rdata;
        end
    end
endmodule
